fifo_syn_param: RTL and testbench

//  Single-clock, parametrised FIFO; next generation of the team's FIFO family.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_ram_2p.sv | 35 +++
 rtl/fifo_syn_param.sv | 87 ++++++++
 tb/tb_fifo_syn_param.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers, status decode and reset constants for the FIFO family
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  localparam logic RST_OVF = 1'b0;
  localparam logic RST_UDF = 1'b0;
  localparam fifo_status_t RST_STATUS = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};

  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return n > 0 && (n & (n - 1)) == 0;
  endfunction

  function automatic fifo_status_t decode_status(input int cnt, input int depth, input int af, input int ae);
    fifo_status_t s;
    s.full = cnt == depth;
    s.empty = cnt == 0;
    s.almost_full = cnt >= af;
    s.almost_empty = cnt <= ae;
    return s;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: DATA_W x DEPTH storage, one sync write port and one read port (registered or async)
module fifo_ram_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_W = clog2(DEPTH),
  parameter bit REG_RD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  if (REG_RD) begin : g_reg
    always_ff @(posedge clk or negedge rst)
      if (!rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
  end else begin : g_async
    logic unused_ok;
    assign unused_ok = &{1'b0, rst, re};
    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/fifo_syn_param.sv
// fifo_syn_param: single-clock parametrised FIFO with thresholds, occupancy, FWFT mode,
// sticky overflow/underflow flags and synchronous flush
module fifo_syn_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4,
  parameter int FWFT = 0,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] Din,
  input  logic              rd,
  output logic [DATA_W-1:0] Dout,
  input  logic              clr,
  input  logic              clr_err,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf
);

  if (DEPTH < 4 || !is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "fifo_syn_param: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_syn_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_syn_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic wa, ra;
  fifo_status_t st;

  // Occupancy is the pointer distance; the extra MSB separates full from empty.
  assign count = wr_ptr - rd_ptr;
  assign st = decode_status(int'(count), DEPTH, AF_THRESH, AE_THRESH);
  assign full = st.full;
  assign empty = st.empty;
  assign almost_full = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign wa = wr & ~full & ~clr;
  assign ra = rd & ~empty & ~clr;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf <= RST_OVF;
      udf <= RST_UDF;
    end else begin
      wr_ptr <= clr ? '0 : wr_ptr + (ADDR_W+1)'(wa);
      rd_ptr <= clr ? '0 : rd_ptr + (ADDR_W+1)'(ra);
      ovf <= (ovf & ~clr_err) | (wr & full & ~clr);
      udf <= (udf & ~clr_err) | (rd & empty & ~clr);
    end

  fifo_ram_2p #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .REG_RD(FWFT == 0)
  ) u_ram (
    .clk(clk),
    .rst(rst),
    .we(wa),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(Din),
    .re(ra),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(rdata)
  );

  // In FWFT mode the head is shown combinationally; blank it while there is no head.
  assign Dout = (FWFT != 0 && empty) ? '0 : rdata;

endmodule

// File: tb/tb_fifo_syn_param.sv
// tb_fifo_syn_param: randomized and directed checks of standard and FWFT FIFOs against a queue model
module tb_fifo_syn_param;

  logic clk = 1'b0, rst = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0, dout0, dout1;
  logic full0, empty0, af0, ae0, ovf0, udf0;
  logic full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] cnt0, cnt1;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic m_ovf = 1'b0, m_udf = 1'b0;
  logic [7:0] m_dout = '0;

  always #5 clk = ~clk;

  fifo_syn_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wr(wr), .Din(din), .rd(rd), .Dout(dout0), .clr(clr), .clr_err(clr_err),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .ovf(ovf0), .udf(udf0)
  );

  fifo_syn_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wr(wr), .Din(din), .rd(rd), .Dout(dout1), .clr(clr), .clr_err(clr_err),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .ovf(ovf1), .udf(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("count0", cnt0, n);
    chk("count1", cnt1, n);
    chk("full0", full0, n == 16);
    chk("full1", full1, n == 16);
    chk("empty0", empty0, n == 0);
    chk("empty1", empty1, n == 0);
    chk("af0", af0, n >= 12);
    chk("af1", af1, n >= 12);
    chk("ae0", ae0, n <= 4);
    chk("ae1", ae1, n <= 4);
    chk("ovf0", ovf0, m_ovf);
    chk("ovf1", ovf1, m_ovf);
    chk("udf0", udf0, m_udf);
    chk("udf1", udf1, m_udf);
    chk("dout0", dout0, m_dout);
    if (n > 0) chk("dout1_head", dout1, q[0]);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_dout = '0;
  endtask

  // One clock: inputs held across the edge, model advanced from pre-edge state, outputs checked 1 time unit later.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c, input logic ce);
    bit was_full, was_empty;
    wr = w; rd = r; din = d; clr = c; clr_err = ce;
    @(posedge clk);
    was_full = q.size() == 16;
    was_empty = q.size() == 0;
    m_ovf = (m_ovf && !ce) || (w && was_full && !c);
    m_udf = (m_udf && !ce) || (r && was_empty && !c);
    if (c) q.delete();
    else begin
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    #2;
    chk("rst_count", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_ae", ae0, 1);
    chk("rst_full", full0, 0);
    chk("rst_af", af0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);
    chk("rst_dout", dout0, 0);
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(i), 0, 0);
    chk("fill_full", full0, 1);
    cyc(1, 0, 8'h11, 0, 0);
    chk("fill_ovf", ovf0, 1);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 8'h00, 0, 0);
      chk("drain_order", dout0, i);
    end
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 1, 8'h00, 0, 0);
    chk("empty_rd_udf", udf0, 1);
    chk("empty_rd_hold", dout0, 8'h10);
    cyc(0, 0, 8'h00, 0, 1);
    chk("udf_cleared", udf0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 1, 8'($urandom), 0, 0);
    chk("steady8", cnt0, 8);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'($urandom), 0, 0);
    cyc(1, 1, 8'hEE, 0, 0);
    chk("full_wrrd_cnt", cnt0, 15);
    chk("full_wrrd_ovf", ovf0, 1);
    cyc(0, 0, 8'h00, 1, 1);
    chk("clr_cnt", cnt0, 0);
    cyc(1, 1, 8'h5A, 0, 0);
    chk("empty_wrrd_cnt", cnt0, 1);
    chk("empty_wrrd_udf", udf0, 1);
    cyc(0, 1, 8'h00, 0, 1);
    cyc(1, 0, 8'hA5, 0, 0);
    chk("fwft_a5", dout1, 8'hA5);
    chk("fwft_notempty", empty1, 0);
    cyc(0, 1, 8'h00, 0, 0);
    chk("fwft_pop_empty", empty1, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'($urandom), 0, 0);
    cyc(1, 0, 8'h77, 1, 0);
    chk("clr_wr_cnt", cnt0, 0);
    chk("clr_wr_empty", empty0, 1);
    for (int i = 0; i < 3000; i++) begin
      int pw = (i / 150) % 3 == 0 ? 80 : (i / 150) % 3 == 1 ? 20 : 50;
      int pr = 100 - pw;
      if (i == 1500) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("midrst_dout1", dout1, 0);
        rst = 1'b1;
      end
      cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom),
          $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
